// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the sram-like to BRAM bridge: size/state enums,
// byte-strobe and misalignment decode, and write-lane replication.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Returns {misalign, strobe}; size 3 is reported as misaligned with no lanes.
    function automatic logic [4:0] strb_of(input logic [1:0] size, input logic [1:0] lo);
        logic [4:0] r;
        case (size)
            SZ_BYTE: r = {1'b0, 4'b0001 << lo};
            SZ_HALF: r = {lo[0], (lo[1] ? 4'b1100 : 4'b0011)};
            SZ_WORD: r = {(lo != 2'b00), 4'b1111};
            default: r = {1'b1, 4'b0000};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wdata[7:0]}};
            SZ_HALF: r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sram_bridge_lane.sv
// Byte-lane decode: strobe, misalignment flag and replicated write data.
// Purely combinational; no latency, no backpressure.
module sram_bridge_lane
    import sram_bridge_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  strb,
    output logic        misalign,
    output logic [31:0] din
);

    logic [4:0] dec;

    assign dec      = strb_of(size, addr_lo);
    assign misalign = dec[4];
    // A misaligned write must not touch memory, so its lanes are suppressed here.
    assign strb     = dec[4] ? 4'b0000 : dec[3:0];
    assign din      = lane_rep(size, wdata);

endmodule

// File: rtl/sram_like_bram_bridge.sv
// Bridges the core's sram-like req/addr_ok/data_ok handshake onto a single-port BRAM.
// Latency: data_ok 1 + WAIT_CYCLES cycles after accept; no backpressure on data_ok.
// Accepts in IDLE only; with SRAM_BRIDGE_PIPE_EN defined, also in RESP.
module sram_like_bram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int LEN_ADDR    = 32,
    parameter int LEN_DATA    = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req,
    input  logic                wr,
    input  logic [1:0]          size,
    input  logic [LEN_ADDR-1:0] addr,
    input  logic [LEN_DATA-1:0] wdata,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [LEN_DATA-1:0] rdata,
    output logic                misalign,
    output logic                bram_en,
    output logic [3:0]          bram_we,
    output logic [LEN_ADDR-1:0] bram_addr,
    output logic [LEN_DATA-1:0] bram_din,
    input  logic [LEN_DATA-1:0] bram_dout
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                cap_q;
    logic                mis_q;
    logic [LEN_DATA-1:0] rdata_q;
    logic                accept;
    logic [3:0]          lane_strb;
    logic                lane_mis;
    logic [31:0]         lane_din;

    sram_bridge_lane u_lane (
        .size     (size),
        .addr_lo  (addr[1:0]),
        .wdata    (wdata),
        .strb     (lane_strb),
        .misalign (lane_mis),
        .din      (lane_din)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_ok = 1'b0;
        case (state_q)
            IDLE: addr_ok = 1'b1;
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
`ifdef SRAM_BRIDGE_PIPE_EN
                addr_ok = 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Nothing may reach the BRAM while reset is held.
        addr_ok = addr_ok & resetn;
        if (req && addr_ok) begin
            state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            cnt_d   = CNT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cap_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= accept;
            if (accept) mis_q   <= lane_mis;
            if (cap_q)  rdata_q <= bram_dout;
        end
    end

    assign accept    = req && addr_ok;
    assign bram_en   = accept;
    assign bram_we   = (accept && wr) ? lane_strb : 4'b0000;
    assign bram_addr = accept ? addr : '0;
    assign bram_din  = accept ? lane_din : '0;

    assign data_ok  = (state_q == RESP);
    assign misalign = mis_q;
    // With no wait states the response cycle is the capture cycle, so forward douta directly.
    assign rdata    = cap_q ? bram_dout : rdata_q;

endmodule

// File: tb/tb_sram_like_bram_bridge.sv
// Directed bench for sram_like_bram_bridge with a behavioural BRAM behind a 0-wait
// and a 3-wait instance; expected responses flow through a scoreboard queue.
module tb_sram_like_bram_bridge;

`ifdef SRAM_BRIDGE_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    typedef struct packed {
        logic        chk_rd;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn0, resetn3, req0, req3, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        addr_ok0, data_ok0, misalign0, bram_en0;
    logic [3:0]  bram_we0;
    logic [31:0] rdata0, bram_addr0, bram_din0, bram_dout0;
    logic        addr_ok3, data_ok3, misalign3, bram_en3;
    logic [3:0]  bram_we3;
    logic [31:0] rdata3, bram_addr3, bram_din3, bram_dout3;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem3 [0:63];

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sram_like_bram_bridge #(.LEN_ADDR(32), .LEN_DATA(32), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .resetn(resetn0), .req(req0), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0),
        .misalign(misalign0), .bram_en(bram_en0), .bram_we(bram_we0),
        .bram_addr(bram_addr0), .bram_din(bram_din0), .bram_dout(bram_dout0)
    );

    sram_like_bram_bridge #(.LEN_ADDR(32), .LEN_DATA(32), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .resetn(resetn3), .req(req3), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3),
        .misalign(misalign3), .bram_en(bram_en3), .bram_we(bram_we3),
        .bram_addr(bram_addr3), .bram_din(bram_din3), .bram_dout(bram_dout3)
    );

    function automatic logic [31:0] init_val(input int k);
        return {16'hC0DE, 8'(k), 8'h5A};
    endfunction

    // Read-first BRAM models; douta holds while en is low. Contents reload under reset.
    always @(posedge clk) begin
        if (!resetn0) begin
            for (int k = 0; k < 64; k++) mem0[k] <= init_val(k);
        end else if (bram_en0) begin
            for (int b = 0; b < 4; b++)
                if (bram_we0[b]) mem0[bram_addr0[7:2]][b*8 +: 8] <= bram_din0[b*8 +: 8];
            bram_dout0 <= mem0[bram_addr0[7:2]];
        end
    end

    always @(posedge clk) begin
        if (!resetn3) begin
            for (int k = 0; k < 64; k++) mem3[k] <= init_val(k);
        end else if (bram_en3) begin
            for (int b = 0; b < 4; b++)
                if (bram_we3[b]) mem3[bram_addr3[7:2]][b*8 +: 8] <= bram_din3[b*8 +: 8];
            bram_dout3 <= mem3[bram_addr3[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input logic mis_obs, input logic [31:0] rd_obs);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_misalign"}, 32'(mis_obs), 32'(e.mis));
            if (e.chk_rd) chk({tag, "_rdata"}, rd_obs, e.rd);
        end
    endtask

    // One access through the zero-wait instance, checked on both the BRAM and core sides.
    task automatic acc0(input string tag, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] exp_we,
                        input logic [31:0] exp_din, input logic exp_mis,
                        input logic chk_rd, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        req0 = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        @(negedge clk);
        chk({tag, "_addr_ok"}, 32'(addr_ok0), 32'd1);
        chk({tag, "_bram_en"}, 32'(bram_en0), 32'd1);
        chk({tag, "_bram_we"}, 32'(bram_we0), 32'(exp_we));
        chk({tag, "_bram_addr"}, bram_addr0, a);
        if (w) chk({tag, "_bram_din"}, bram_din0, exp_din);
        sb.push_back({chk_rd, exp_mis, exp_rd});
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk({tag, "_data_ok"}, 32'(data_ok0), 32'd1);
        chk({tag, "_resp_addr_ok"}, 32'(addr_ok0), 32'(PIPE));
        pop_cmp(tag, misalign0, rdata0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, nresp, first_acc, last_acc, run, maxrun;

        resetn0 = 1'b0; resetn3 = 1'b0; req0 = 1'b1; req3 = 1'b1;
        wr = 1'b0; size = 2'd2; addr = 32'h10; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bram_en0", 32'(bram_en0), 32'd0);
        chk("rst_data_ok0", 32'(data_ok0), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_misalign0", 32'(misalign0), 32'd0);
        chk("rst_bram_en3", 32'(bram_en3), 32'd0);
        chk("rst_data_ok3", 32'(data_ok3), 32'd0);
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0; resetn0 = 1'b1; resetn3 = 1'b1;
        @(negedge clk);
        chk("post_rst_addr_ok0", 32'(addr_ok0), 32'd1);
        chk("post_rst_addr_ok3", 32'(addr_ok3), 32'd1);
        chk("post_rst_data_ok0", 32'(data_ok0), 32'd0);

        acc0("wr_word", 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        acc0("rd_word", 1'b0, 2'd2, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        acc0("wr_byte", 1'b1, 2'd0, 32'h13, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
        acc0("rd_byte", 1'b0, 2'd2, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hA5ADBEEF);
        acc0("wr_half_mis", 1'b1, 2'd1, 32'h11, 32'h00001234, 4'b0000, 32'h12341234, 1'b1, 1'b0, 32'h0);
        acc0("rd_after_mis", 1'b0, 2'd2, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hA5ADBEEF);
        acc0("wr_half_hi", 1'b1, 2'd1, 32'h12, 32'h00005566, 4'b1100, 32'h55665566, 1'b0, 1'b0, 32'h0);
        acc0("rd_half", 1'b0, 2'd2, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h5566BEEF);
        acc0("wr_byte_l1", 1'b1, 2'd0, 32'h11, 32'h00000077, 4'b0010, 32'h77777777, 1'b0, 1'b0, 32'h0);
        acc0("rd_size3", 1'b0, 2'd3, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1, 32'h556677EF);
        acc0("rd_wrap", 1'b0, 2'd2, 32'hFFFFFF10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h556677EF);
        acc0("wr_word_mis", 1'b1, 2'd2, 32'h12, 32'h01020304, 4'b0000, 32'h01020304, 1'b1, 1'b0, 32'h0);

        // Three wait states: req held high through WAIT must be ignored.
        @(posedge clk); #1;
        req3 = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
        @(negedge clk);
        chk("w3_accept_addr_ok", 32'(addr_ok3), 32'd1);
        chk("w3_accept_bram_en", 32'(bram_en3), 32'd1);
        sb.push_back({1'b1, 1'b0, init_val(4)});
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("w3_wait_addr_ok", 32'(addr_ok3), 32'd0);
            chk("w3_wait_data_ok", 32'(data_ok3), 32'd0);
            chk("w3_wait_bram_en", 32'(bram_en3), 32'd0);
        end
        @(posedge clk); #1;
        req3 = 1'b0;
        @(negedge clk);
        chk("w3_data_ok", 32'(data_ok3), 32'd1);
        pop_cmp("w3_resp", misalign3, rdata3);
        @(negedge clk);
        chk("w3_data_ok_drop", 32'(data_ok3), 32'd0);

        // Reset in the middle of WAIT drops the access.
        @(posedge clk); #1;
        req3 = 1'b1;
        @(negedge clk);
        chk("w3rst_accept", 32'(bram_en3), 32'd1);
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        resetn3 = 1'b0;
        @(negedge clk);
        chk("w3rst_data_ok", 32'(data_ok3), 32'd0);
        chk("w3rst_rdata", rdata3, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("w3rst_no_data_ok", 32'(data_ok3), 32'd0);
        end
        chk("w3rst_addr_ok", 32'(addr_ok3), 32'd1);

        // Back-to-back word reads at 0x0/4/8/C with req held high.
        nacc = 0; nresp = 0; first_acc = 0; last_acc = 0; run = 0; maxrun = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (nacc < 4) begin
                req0 = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'(nacc * 4);
            end else begin
                req0 = 1'b0;
            end
            @(negedge clk);
            if (data_ok0) begin
                pop_cmp("b2b", misalign0, rdata0);
                nresp++;
                run++;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
            if (bram_en0) begin
                sb.push_back({1'b1, 1'b0, init_val(nacc)});
                if (nacc == 0) first_acc = cyc;
                last_acc = cyc;
                nacc++;
            end
        end
        req0 = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd4);
        chk("b2b_responses", 32'(nresp), 32'd4);
        chk("b2b_accept_span", 32'(last_acc - first_acc), PIPE ? 32'd3 : 32'd6);
        chk("b2b_data_ok_run", 32'(maxrun), PIPE ? 32'd4 : 32'd1);
        chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
